// File: rtl/dvp_bayer_capture.sv
// DVP RAW8 capture: registers the camera port, locks onto frame boundaries and
// emits one pixel per clock with a linear y*size_x+x frame address.
module dvp_bayer_capture #(
  parameter int size_x = 640,
  parameter int size_y = 480,
  parameter int ADDR_W = 19
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              vsync,
  input  logic              href,
  input  logic [7:0]        data_in,
  output logic [7:0]        raw,
  output logic [ADDR_W-1:0] address,
  output logic              pixel_valid,
  output logic              frame_start,
  output logic              frame_done,
  output logic              line_error,
  output logic [7:0]        frame_count
);

  localparam int X_W = $clog2(size_x + 1);
  localparam int Y_W = $clog2(size_y + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(size_x * size_y - 1);
  localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(size_x);

  typedef enum logic [1:0] {SYNC, VBLANK, ACTIVE} state_t;

  state_t state;
  state_t state_next;

  logic              s_vsync;
  logic              s_href;
  logic [7:0]        s_data;
  logic              vsync_d;
  logic              href_d;
  logic [X_W-1:0]    x;
  logic [Y_W-1:0]    y;
  logic [ADDR_W-1:0] addr_cnt;
  logic [ADDR_W-1:0] line_base;
  logic              x_full;
  logic              y_full;

  assign x_full = (x == X_W'(size_x));
  assign y_full = (y == Y_W'(size_y));

  always_ff @(posedge clock) begin
    if (reset) begin
      s_vsync <= 1'b0;
      s_href  <= 1'b0;
      s_data  <= 8'd0;
      vsync_d <= 1'b0;
      href_d  <= 1'b0;
    end else begin
      s_vsync <= vsync;
      s_href  <= href;
      s_data  <= data_in;
      vsync_d <= s_vsync;
      href_d  <= s_href;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) state <= SYNC;
    else       state <= state_next;
  end

  // SYNC waits for a real vsync rising edge so a partially seen frame is never emitted.
  always_comb begin
    state_next = state;
    case (state)
      SYNC:    if (s_vsync && !vsync_d) state_next = VBLANK;
      VBLANK:  if (!s_vsync) state_next = ACTIVE;
      ACTIVE:  if (s_vsync) state_next = VBLANK;
      default: state_next = SYNC;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      raw         <= 8'd0;
      address     <= '0;
      pixel_valid <= 1'b0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      line_error  <= 1'b0;
      frame_count <= 8'd0;
      x           <= '0;
      y           <= '0;
      addr_cnt    <= '0;
      line_base   <= '0;
    end else begin
      pixel_valid <= 1'b0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      case (state)
        ACTIVE: begin
          if (s_vsync) begin
            if (!y_full) line_error <= 1'b1;
            x <= '0;
            y <= '0;
          end else if (s_href) begin
            // An href cycle past a full line means the line is too long.
            if (x_full) line_error <= 1'b1;
            else        x <= x + X_W'(1);
            if (!x_full && !y_full) begin
              raw         <= s_data;
              address     <= addr_cnt;
              pixel_valid <= 1'b1;
              addr_cnt    <= addr_cnt + ADDR_W'(1);
              frame_start <= (x == '0) && (y == '0);
              // A frame that already saw a bad line is not counted as completed.
              if (addr_cnt == LAST_ADDR && !line_error) begin
                frame_done  <= 1'b1;
                frame_count <= frame_count + 8'd1;
              end
            end
          end else if (href_d) begin
            if (!x_full) line_error <= 1'b1;
            x <= '0;
            // Rebasing from line_base keeps later lines aligned after a short line.
            if (!y_full) begin
              y         <= y + Y_W'(1);
              line_base <= line_base + LINE_STEP;
              addr_cnt  <= line_base + LINE_STEP;
            end
          end
        end
        default: begin
          x         <= '0;
          y         <= '0;
          addr_cnt  <= '0;
          line_base <= '0;
          if (state == VBLANK && !s_vsync) line_error <= 1'b0;
        end
      endcase
    end
  end

endmodule
